// File: rtl/dsp19x2_result_acc.sv
// dsp19x2_result_acc: windowed dual-lane accumulator for packed DSP19X2 products; `DSP19X2_ACC_SAT_EN enables saturation
module dsp19x2_result_acc #(
  parameter int ACC_W = 24,
  parameter int LEN = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [37:0]      Z_IN,
  input  logic             Z_VALID,
  output logic             Z_READY,
  input  logic             UNSIGNED,
  output logic [ACC_W-1:0] ACC1,
  output logic [ACC_W-1:0] ACC2,
  output logic             SAT1,
  output logic             SAT2,
  output logic             ACC_VALID,
  input  logic             ACC_READY
);
  localparam int CW = $clog2(LEN + 1);
  localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2;
  logic [1:0] state, state_n;
  logic [CW-1:0] cnt;
  logic mode_r, mode, first, acc_en;
  logic [ACC_W:0] r1, r2;
  // One lane step: extend accumulator and lane to ACC_W+1 bits, add, then clamp or wrap; MSB of the result is the overflow flag
  function automatic logic [ACC_W:0] step(input logic [ACC_W-1:0] a, input logic [18:0] z, input logic u, input logic f);
    logic [ACC_W:0] b, e;
`ifdef DSP19X2_ACC_SAT_EN
    logic [ACC_W:0] s;
`endif
    b = f ? '0 : (u ? {1'b0, a} : {a[ACC_W-1], a});
    e = u ? {{(ACC_W-18){1'b0}}, z} : {{(ACC_W-18){z[18]}}, z};
`ifdef DSP19X2_ACC_SAT_EN
    s = b + e;
    if (u ? s[ACC_W] : s[ACC_W] ^ s[ACC_W-1])
      return {1'b1, u ? {ACC_W{1'b1}} : {s[ACC_W], {(ACC_W-1){~s[ACC_W]}}}};
    return {1'b0, s[ACC_W-1:0]};
`else
    return {1'b0, ACC_W'(b + e)};
`endif
  endfunction
  assign acc_en = Z_VALID & Z_READY;
  assign first = state == IDLE;
  assign mode = first ? UNSIGNED : mode_r;
  assign ACC_VALID = state == HOLD;
  // Next state and per-lane next accumulator values
  always_comb begin
    state_n = first ? (acc_en ? (LEN == 1 ? HOLD : ACCUM) : IDLE)
            : state == ACCUM ? (acc_en && cnt == CW'(LEN - 1) ? HOLD : ACCUM)
            : (ACC_READY ? IDLE : HOLD);
    r1 = step(ACC1, Z_IN[18:0], mode, first);
    r2 = step(ACC2, Z_IN[37:19], mode, first);
  end
  // Window state, accumulators, sticky flags and registered ready
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cnt <= '0;
      mode_r <= 1'b0;
      ACC1 <= '0;
      ACC2 <= '0;
      SAT1 <= 1'b0;
      SAT2 <= 1'b0;
      Z_READY <= 1'b0;
    end else begin
      state <= state_n;
      Z_READY <= state_n != HOLD;
      if (acc_en) begin
        ACC1 <= r1[ACC_W-1:0];
        ACC2 <= r2[ACC_W-1:0];
        SAT1 <= r1[ACC_W] | (SAT1 & ~first);
        SAT2 <= r2[ACC_W] | (SAT2 & ~first);
        cnt <= cnt + 1'b1;
        if (first) mode_r <= UNSIGNED;
      end else if (ACC_VALID && ACC_READY) begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dsp19x2_result_acc.sv
// tb_dsp19x2_result_acc: two instances (24-bit/LEN 4, 20-bit/LEN 3) checked against a window-level model plus literal cases
module tb_dsp19x2_result_acc;
  logic clk = 1'b0, rst = 1'b1;
  logic [37:0] z_in = '0;
  logic zv = 1'b0, uns = 1'b0, ard = 1'b0;
  logic a_zr, a_s1, a_s2, a_v, b_zr, b_s1, b_s2, b_v;
  logic [23:0] a_acc1, a_acc2;
  logic [19:0] b_acc1, b_acc2;
  int tests = 0, fails = 0;
  int W[2] = '{24, 20};
  int L[2] = '{4, 3};
  bit m_hold[2], m_rdy[2], m_mode[2], m_sat1[2], m_sat2[2];
  int m_cnt[2];
  longint m_s1[2], m_s2[2];
  bit o1, o2;

  always #5 clk = ~clk;

  dsp19x2_result_acc #(.ACC_W(24), .LEN(4)) dut_a (
    .CLK(clk), .RESET(rst), .Z_IN(z_in), .Z_VALID(zv), .Z_READY(a_zr), .UNSIGNED(uns),
    .ACC1(a_acc1), .ACC2(a_acc2), .SAT1(a_s1), .SAT2(a_s2), .ACC_VALID(a_v), .ACC_READY(ard));
  dsp19x2_result_acc #(.ACC_W(20), .LEN(3)) dut_b (
    .CLK(clk), .RESET(rst), .Z_IN(z_in), .Z_VALID(zv), .Z_READY(b_zr), .UNSIGNED(uns),
    .ACC1(b_acc1), .ACC2(b_acc2), .SAT1(b_s1), .SAT2(b_s2), .ACC_VALID(b_v), .ACC_READY(ard));

  task automatic chk(input string name, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic longint lane(input logic [18:0] z, input bit u);
    return (u || !z[18]) ? longint'(z) : longint'(z) - 524288;
  endfunction

  function automatic longint clampv(input longint v, input bit u, input int w, output bit s);
    longint r = v;
    s = 1'b0;
`ifdef DSP19X2_ACC_SAT_EN
    begin
      longint lo = u ? 0 : -(longint'(1) << (w - 1));
      longint hi = u ? (longint'(1) << w) - 1 : (longint'(1) << (w - 1)) - 1;
      if (r > hi) begin r = hi; s = 1'b1; end
      if (r < lo) begin r = lo; s = 1'b1; end
    end
`endif
    return r;
  endfunction

  // Window-level reference: accepts while not holding a result, emits after L words
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_hold[i] = 0; m_rdy[i] = 0; m_cnt[i] = 0; m_s1[i] = 0; m_s2[i] = 0; m_sat1[i] = 0; m_sat2[i] = 0;
      end else begin
        if (zv && m_rdy[i]) begin
          if (m_cnt[i] == 0) begin
            m_mode[i] = uns; m_s1[i] = 0; m_s2[i] = 0; m_sat1[i] = 0; m_sat2[i] = 0;
          end
          m_s1[i] = clampv(m_s1[i] + lane(z_in[18:0], m_mode[i]), m_mode[i], W[i], o1);
          m_s2[i] = clampv(m_s2[i] + lane(z_in[37:19], m_mode[i]), m_mode[i], W[i], o2);
          m_sat1[i] |= o1;
          m_sat2[i] |= o2;
          m_cnt[i]++;
          if (m_cnt[i] == L[i]) m_hold[i] = 1;
        end else if (m_hold[i] && ard) begin
          m_hold[i] = 0; m_cnt[i] = 0;
        end
        m_rdy[i] = !m_hold[i];
      end
    end
  end

  task automatic cmp(input int i, input bit zr, input bit v, input longint a1, input longint a2, input bit s1, input bit s2);
    longint mk = (longint'(1) << W[i]) - 1;
    chk($sformatf("d%0d_z_ready", i), zr, m_rdy[i]);
    chk($sformatf("d%0d_acc_valid", i), v, m_hold[i]);
    if (m_hold[i]) begin
      chk($sformatf("d%0d_acc1", i), a1, m_s1[i] & mk);
      chk($sformatf("d%0d_acc2", i), a2, m_s2[i] & mk);
      chk($sformatf("d%0d_sat1", i), s1, m_sat1[i]);
      chk($sformatf("d%0d_sat2", i), s2, m_sat2[i]);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    cmp(0, a_zr, a_v, longint'(a_acc1), longint'(a_acc2), a_s1, a_s2);
    cmp(1, b_zr, b_v, longint'(b_acc1), longint'(b_acc2), b_s1, b_s2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_zr"}, a_zr, 0); chk({tag, "_a_v"}, a_v, 0);
    chk({tag, "_a_acc1"}, a_acc1, 0); chk({tag, "_a_acc2"}, a_acc2, 0);
    chk({tag, "_a_sat"}, {a_s1, a_s2}, 0);
    chk({tag, "_b_zr"}, b_zr, 0); chk({tag, "_b_v"}, b_v, 0);
    chk({tag, "_b_acc1"}, b_acc1, 0); chk({tag, "_b_sat"}, {b_s1, b_s2}, 0);
  endtask

  task automatic do_reset();
    rst = 1; zv = 0; ard = 0;
    tick(); tick();
    chk_zero("rst");
    rst = 0;
    tick();
    chk("rel_a_zr", a_zr, 1);
    chk("rel_b_zr", b_zr, 1);
  endtask

  initial begin
    do_reset();
    // unsigned accumulate, then backpressure with changing payload
    uns = 1; zv = 1; z_in = {19'd1, 19'd522753};
    repeat (4) tick();
    chk("uns_valid", a_v, 1);
    chk("uns_acc1", a_acc1, 2091012);
    chk("uns_acc2", a_acc2, 4);
    chk("uns_sat", {a_s1, a_s2}, 0);
    repeat (5) begin
      z_in = 38'({$urandom(), $urandom()});
      tick();
    end
    chk("bp_acc1", a_acc1, 2091012);
    chk("bp_zr", a_zr, 0);
    ard = 1; zv = 0;
    tick();
    chk("post_present_zr", a_zr, 1);
    chk("post_present_v", a_v, 0);
    // signed saturation on the 20-bit instance
    do_reset();
    uns = 0; zv = 1; z_in = {19'd0, 19'h40000};
    repeat (3) tick();
    chk("sgn_b_valid", b_v, 1);
`ifdef DSP19X2_ACC_SAT_EN
    chk("sgn_b_acc1", b_acc1, 20'h80000);
    chk("sgn_b_sat1", b_s1, 1);
`else
    chk("sgn_b_acc1", b_acc1, 20'h40000);
    chk("sgn_b_sat1", b_s1, 0);
`endif
    chk("sgn_b_sat2", b_s2, 0);
    tick();
    chk("sgn_a_acc1", a_acc1, 24'hF00000);
    chk("sgn_a_sat1", a_s1, 0);
    ard = 1; zv = 0;
    tick();
    // gapped input with a mode flip after the first accept
    do_reset();
    uns = 0; zv = 1; z_in = {19'd0, 19'h7FFFF};
    tick();
    uns = 1; zv = 0; tick();
    zv = 1; tick();
    zv = 0; tick();
    zv = 1; tick();
    chk("gap_b_valid", b_v, 1);
    chk("gap_b_acc1", b_acc1, 20'hFFFFD);
    chk("gap_b_sat1", b_s1, 0);
    // reset mid-window, then a clean window from zero
    rst = 1; zv = 0;
    tick();
    chk_zero("mid");
    rst = 0;
    tick();
    uns = 0; zv = 1; z_in = {19'd7, 19'd5};
    repeat (4) tick();
    chk("fresh_acc1", a_acc1, 20);
    chk("fresh_acc2", a_acc2, 28);
    ard = 1; zv = 0;
    tick();
    // randomized traffic, extremes mixed in
    for (int n = 0; n < 3000; n++) begin
      logic [18:0] p, q;
      p = 19'($urandom());
      q = 19'($urandom());
      if ($urandom_range(0, 3) == 0) p = $urandom_range(0, 1) ? 19'h40000 : 19'h3FFFF;
      if ($urandom_range(0, 3) == 0) q = $urandom_range(0, 1) ? 19'h7FFFF : 19'h3FFFF;
      z_in = {q, p};
      zv = $urandom_range(0, 9) < 7;
      uns = 1'($urandom_range(0, 1));
      ard = 1'($urandom_range(0, 1));
      rst = $urandom_range(0, 299) == 0;
      tick();
    end
    rst = 0; zv = 0; ard = 1;
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
